pe_sequencer: RTL and testbench
===============================

Name: pe_sequencer

Overview:
- Control FSM for the single-PE convolution datapath (IFMap/filter scratch pads, MAC pipeline, Psum FIFO).
- Loads stride and filter-size config, paces put_data/put_filter against datapath availability, and steps filters and rows.
- Drains the 3-stage MAC pipeline and reports completion to the top-level/host.

Parameters:
ROW_CNT_W, 8, width of the output-row count input and the internal row counter
FILT_CNT_W, 8, width of the internal filter-window counter
PIPE_DRAIN, 3, cycles waited after the last row before done (line0..line2 depth)
DRAIN_CNT_W, 2, width of the drain counter; must hold PIPE_DRAIN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin one convolution job; sampled only in IDLE
num_rows  in  ROW_CNT_W  output rows to process; sampled on start; 0 treated as 1
av_data  in  1  IFMap window element available
av_filter  in  1  filter element available
co_filter  in  1  last element of the current filter window is being issued
end_of_row  in  1  IFMap row exhausted
end_of_filter  in  1  filter scratch pad exhausted (informational, latched into status)
ld_stride  out  1  stride register load pulse
ld_fileSize  out  1  filter-size register load pulse
clear_sum  out  1  clears buffers/accumulator
put_data  out  1  issue IFMap element
put_filter  out  1  issue filter element
chip_en  out  1  filter scratch pad enable
next_filter  out  1  advance to next filter window
next_row  out  1  advance to next IFMap row
busy  out  1  high from CONFIG through FINISH
done  out  1  single-cycle completion pulse

Behaviour:
- Reset: state=IDLE; all outputs 0; all counters 0. Reset mid-job aborts immediately; no done pulse.
- All outputs are registered-state decodes (Moore) except put_data/put_filter/chip_en, which are MAC-state gated by av_data&&av_filter (Mealy, same cycle).
- IDLE: start=1 -> CONFIG; latch max(num_rows,1). start while busy is ignored.
- CONFIG (1 cycle): ld_stride=ld_fileSize=clear_sum=1 -> FETCH.
- FETCH: wait for av_data&&av_filter; both high -> MAC (no issue this cycle).
- MAC: each cycle with av_data&&av_filter -> put_data=put_filter=chip_en=1; otherwise all three 0 (stall, remain MAC). co_filter=1 coincident with an issue -> FILTER_END. co_filter without issue is ignored.
- FILTER_END (1 cycle): next_filter=1; filt_cnt++ (wraps). end_of_row=1 -> ROW_END, else -> FETCH.
- ROW_END (1 cycle): next_row=1; row_cnt++. If row_cnt == rows_latched-1 (pre-increment) -> DRAIN, else filt_cnt=0 -> FETCH.
- DRAIN: count PIPE_DRAIN cycles; then -> FINISH.
- FINISH (1 cycle): done=1 -> IDLE; busy drops the following cycle.
- Latency: start to first put_data is 2 cycles minimum (CONFIG, FETCH).
- Row counter compare is done at ROW_CNT_W bits; num_rows = 2^ROW_CNT_W-1 must complete without wrap.

Optional Feature:
PE_SEQ_PERF_EN: adds outputs stall_cycles[15:0] (MAC cycles without issue) and mac_cycles[15:0] (issue cycles). Both clear on CONFIG and saturate at 0xFFFF. Without the macro, the ports and logic are absent; control behaviour is identical.

Decomposition:
- Package pe_seq_pkg: state enum typedef (IDLE, CONFIG, FETCH, MAC, FILTER_END, ROW_END, DRAIN, FINISH) and the default PIPE_DRAIN constant.
- One natural sub-module, pe_seq_perf (saturating counter pair), instantiated only under PE_SEQ_PERF_EN.

Test Plan:
- start with num_rows=1, av_* held high, co_filter after 9 issues, end_of_row at the first FILTER_END -> exactly 9 put_data pulses, 1 next_filter, 1 next_row, done 3+1 cycles after ROW_END.
- av_data toggling 1/0 during MAC -> put_data only in av-high cycles; with perf enabled, stall_cycles equals the number of low cycles.
- num_rows=3, end_of_row on every 2nd FILTER_END -> 6 next_filter, 3 next_row, single done.
- num_rows=0 -> behaves as 1 row.
- rst asserted in MAC -> next cycle all outputs 0, busy=0, no done; a new start then runs normally.
- start asserted while busy -> ignored; done count = 1.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the single-PE convolution sequencer.
package pe_seq_pkg;

   // Default MAC pipeline depth (line0..line2) drained before completion
   localparam int unsigned PIPE_DRAIN_DEF = 3;

   // Width of the optional performance counters
   localparam int unsigned PERF_CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONFIG,
      S_FETCH,
      S_MAC,
      S_FILTER_END,
      S_ROW_END,
      S_DRAIN,
      S_FINISH
   } seq_state_e;

endpackage : pe_seq_pkg

// File: rtl/pe_seq_perf.sv
// Saturating stall/issue cycle counter pair for the PE sequencer MAC phase.
module pe_seq_perf
   import pe_seq_pkg::*;
#(
   parameter int unsigned CNT_W = PERF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             mac_i,
   input  logic             issue_i,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] mac_cycles_o
);

   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] mac_q, mac_d;

   // Next-count: clear on job config, otherwise count MAC cycles by issue/stall, saturating
   always_comb begin
      stall_d = stall_q;
      mac_d   = mac_q;
      if (clear_i) begin
         stall_d = '0;
         mac_d   = '0;
      end else if (mac_i) begin
         if (issue_i) begin
            if (mac_q != '1) mac_d = mac_q + CNT_W'(1);
         end else begin
            if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         mac_q   <= '0;
      end else begin
         stall_q <= stall_d;
         mac_q   <= mac_d;
      end
   end

   assign stall_cycles_o = stall_q;
   assign mac_cycles_o   = mac_q;

endmodule : pe_seq_perf

// File: rtl/pe_sequencer.sv
// Control FSM for the single-PE convolution datapath: config load, issue pacing,
// filter/row stepping, MAC pipeline drain and completion pulse.
// Optional feature macro: PE_SEQ_PERF_EN adds stall_cycles/mac_cycles counters.
module pe_sequencer
   import pe_seq_pkg::*;
#(
   parameter int unsigned ROW_CNT_W   = 8,
   parameter int unsigned FILT_CNT_W  = 8,
   parameter int unsigned PIPE_DRAIN  = PIPE_DRAIN_DEF,
   parameter int unsigned DRAIN_CNT_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ROW_CNT_W-1:0] num_rows,
   input  logic                 av_data,
   input  logic                 av_filter,
   input  logic                 co_filter,
   input  logic                 end_of_row,
   input  logic                 end_of_filter,
   output logic                 ld_stride,
   output logic                 ld_fileSize,
   output logic                 clear_sum,
   output logic                 put_data,
   output logic                 put_filter,
   output logic                 chip_en,
   output logic                 next_filter,
   output logic                 next_row,
   output logic                 busy,
   output logic                 done
`ifdef PE_SEQ_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cycles,
   output logic [PERF_CNT_W-1:0] mac_cycles
`endif
);

   seq_state_e             state_q, state_d;
   logic [ROW_CNT_W-1:0]   rows_m1_q, rows_m1_d;
   logic [ROW_CNT_W-1:0]   row_cnt_q, row_cnt_d;
   logic [FILT_CNT_W-1:0]  filt_cnt_q, filt_cnt_d;
   logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic                   eof_seen_q, eof_seen_d;
   logic                   issue_c;

   // Both operands present: an element pair can be issued this cycle
   assign issue_c = av_data && av_filter;

   // Next-state, counter updates and output decode
   always_comb begin
      state_d     = state_q;
      rows_m1_d   = rows_m1_q;
      row_cnt_d   = row_cnt_q;
      filt_cnt_d  = filt_cnt_q;
      drain_cnt_d = drain_cnt_q;
      eof_seen_d  = eof_seen_q;
      ld_stride   = 1'b0;
      ld_fileSize = 1'b0;
      clear_sum   = 1'b0;
      put_data    = 1'b0;
      put_filter  = 1'b0;
      chip_en     = 1'b0;
      next_filter = 1'b0;
      next_row    = 1'b0;
      done        = 1'b0;
      busy        = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CONFIG;
               // Store rows-1 so a zero request behaves as a single row and the
               // full-scale count compares without wrapping
               rows_m1_d = (num_rows == '0) ? '0 : num_rows - ROW_CNT_W'(1);
            end
         end
         S_CONFIG: begin
            ld_stride   = 1'b1;
            ld_fileSize = 1'b1;
            clear_sum   = 1'b1;
            row_cnt_d   = '0;
            filt_cnt_d  = '0;
            drain_cnt_d = '0;
            eof_seen_d  = 1'b0;
            state_d     = S_FETCH;
         end
         S_FETCH: begin
            if (issue_c) state_d = S_MAC;
         end
         S_MAC: begin
            put_data   = issue_c;
            put_filter = issue_c;
            chip_en    = issue_c;
            if (issue_c && co_filter) state_d = S_FILTER_END;
         end
         S_FILTER_END: begin
            next_filter = 1'b1;
            filt_cnt_d  = filt_cnt_q + FILT_CNT_W'(1);
            state_d     = end_of_row ? S_ROW_END : S_FETCH;
         end
         S_ROW_END: begin
            next_row  = 1'b1;
            row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
            if (row_cnt_q == rows_m1_q) begin
               drain_cnt_d = '0;
               state_d     = S_DRAIN;
            end else begin
               filt_cnt_d = '0;
               state_d    = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == DRAIN_CNT_W'(PIPE_DRAIN - 1)) begin
               state_d = S_FINISH;
            end else begin
               drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
            end
         end
         S_FINISH: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Sticky status: filter scratch pad ran out during the active job
      if (state_q != S_IDLE && state_q != S_CONFIG && end_of_filter) eof_seen_d = 1'b1;
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rows_m1_q   <= '0;
         row_cnt_q   <= '0;
         filt_cnt_q  <= '0;
         drain_cnt_q <= '0;
         eof_seen_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_m1_q   <= rows_m1_d;
         row_cnt_q   <= row_cnt_d;
         filt_cnt_q  <= filt_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         eof_seen_q  <= eof_seen_d;
      end
   end

`ifdef PE_SEQ_PERF_EN
   logic in_mac_c;
   logic in_config_c;

   assign in_mac_c    = (state_q == S_MAC);
   assign in_config_c = (state_q == S_CONFIG);

   pe_seq_perf #(
      .CNT_W (PERF_CNT_W)
   ) u_perf (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (in_config_c),
      .mac_i          (in_mac_c),
      .issue_i        (issue_c),
      .stall_cycles_o (stall_cycles),
      .mac_cycles_o   (mac_cycles)
   );
`else
   // Performance counters not built; control path is unchanged.
`endif

endmodule : pe_sequencer

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: each job is planned as rows x filters x
// issues-per-filter and the expected per-cycle output vector is derived from that plan.
module tb_pe_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] num_rows;
   logic       av_data, av_filter, co_filter, end_of_row, end_of_filter;
   logic       ld_stride, ld_fileSize, clear_sum, put_data, put_filter, chip_en;
   logic       next_filter, next_row, busy, done;
`ifdef PE_SEQ_PERF_EN
   logic [15:0] stall_cycles, mac_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0, put_cnt = 0, nf_cnt = 0, nr_cnt = 0;
   bit tog = 1'b1;

   // Output vector order: ld_stride ld_fileSize clear_sum put_data put_filter chip_en next_filter next_row busy done
   localparam logic [9:0] E_IDLE  = 10'b0000000000;
   localparam logic [9:0] E_CFG   = 10'b1110000010;
   localparam logic [9:0] E_BUSY  = 10'b0000000010;
   localparam logic [9:0] E_ISSUE = 10'b0001110010;
   localparam logic [9:0] E_NF    = 10'b0000001010;
   localparam logic [9:0] E_NR    = 10'b0000000110;
   localparam logic [9:0] E_DONE  = 10'b0000000011;

   pe_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_rows      (num_rows),
      .av_data       (av_data),
      .av_filter     (av_filter),
      .co_filter     (co_filter),
      .end_of_row    (end_of_row),
      .end_of_filter (end_of_filter),
      .ld_stride     (ld_stride),
      .ld_fileSize   (ld_fileSize),
      .clear_sum     (clear_sum),
      .put_data      (put_data),
      .put_filter    (put_filter),
      .chip_en       (chip_en),
      .next_filter   (next_filter),
      .next_row      (next_row),
      .busy          (busy),
      .done          (done)
`ifdef PE_SEQ_PERF_EN
      ,
      .stall_cycles  (stall_cycles),
      .mac_cycles    (mac_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (done === 1'b1)        done_cnt++;
      if (put_data === 1'b1)    put_cnt++;
      if (next_filter === 1'b1) nf_cnt++;
      if (next_row === 1'b1)    nr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply current inputs for one cycle and compare outputs at the falling edge
   task automatic step(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      @(negedge clk);
      obs = {ld_stride, ld_fileSize, clear_sum, put_data, put_filter, chip_en,
             next_filter, next_row, busy, done};
      check(tag, 32'(obs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   // Availability pattern: 0 always ready, 1 av_data toggles, 2 random
   task automatic set_av(input int mode);
      end_of_filter = 1'($urandom_range(0, 1));
      case (mode)
         0: begin av_data = 1'b1; av_filter = 1'b1; end
         1: begin av_data = tog; tog = ~tog; av_filter = 1'b1; end
         default: begin
            av_data   = ($urandom_range(0, 3) != 0);
            av_filter = ($urandom_range(0, 3) != 0);
         end
      endcase
   endtask

   task automatic run_job(input int n, input int fpr, input int k, input int mode, input bit poke);
      int rows, issues, stalls, cnt, d0, p0, f0, r0;
      bit iss;
      rows = (n == 0) ? 1 : n;
      issues = 0; stalls = 0;
      d0 = done_cnt; p0 = put_cnt; f0 = nf_cnt; r0 = nr_cnt;
      start = 1'b1; num_rows = 8'(n); co_filter = 1'b0; end_of_row = 1'b0;
      step("idle_start", E_IDLE);
      start = poke;
      num_rows = 8'($urandom_range(0, 255));
      step("config", E_CFG);
      for (int r = 0; r < rows; r++) begin
         for (int f = 0; f < fpr; f++) begin
            do begin
               set_av(mode);
               co_filter  = 1'($urandom_range(0, 1));
               end_of_row = 1'($urandom_range(0, 1));
               start      = poke ? 1'($urandom_range(0, 1)) : 1'b0;
               step("fetch", E_BUSY);
            end while (!(av_data && av_filter));
            cnt = 0;
            do begin
               set_av(mode);
               iss = av_data && av_filter;
               co_filter  = iss ? (cnt == k - 1) : 1'($urandom_range(0, 1));
               end_of_row = 1'($urandom_range(0, 1));
               start      = poke ? 1'($urandom_range(0, 1)) : 1'b0;
               step("mac", iss ? E_ISSUE : E_BUSY);
               if (iss) begin cnt++; issues++; end
               else stalls++;
            end while (cnt < k);
            set_av(mode);
            co_filter  = 1'($urandom_range(0, 1));
            end_of_row = (f == fpr - 1);
            step("filter_end", E_NF);
         end
         set_av(mode);
         end_of_row = 1'($urandom_range(0, 1));
         step("row_end", E_NR);
      end
      for (int i = 0; i < 3; i++) begin
         start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         step("drain", E_BUSY);
      end
      start = 1'b0;
      step("finish", E_DONE);
      step("idle_after", E_IDLE);
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("put_data_count", 32'(put_cnt - p0), 32'(rows * fpr * k));
      check("next_filter_count", 32'(nf_cnt - f0), 32'(rows * fpr));
      check("next_row_count", 32'(nr_cnt - r0), 32'(rows));
`ifdef PE_SEQ_PERF_EN
      check("mac_cycles", 32'(mac_cycles), 32'(issues));
      check("stall_cycles", 32'(stall_cycles), 32'(stalls));
`endif
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; num_rows = '0;
      av_data = 1'b0; av_filter = 1'b0; co_filter = 1'b0;
      end_of_row = 1'b0; end_of_filter = 1'b0;
      #1;
      step("reset0", E_IDLE);
      start = 1'b1;
      step("reset1", E_IDLE);
      rst = 1'b0; start = 1'b0;
      step("post_reset_idle", E_IDLE);

      run_job(1, 1, 9, 0, 1'b0);
      run_job(1, 1, 6, 1, 1'b0);
      run_job(3, 2, 3, 2, 1'b0);
      run_job(0, 1, 4, 0, 1'b0);

      // Abort in MAC: no done, outputs quiet next cycle, then a clean job
      d0 = done_cnt;
      start = 1'b1; num_rows = 8'd2;
      step("rst_idle_start", E_IDLE);
      start = 1'b0; av_data = 1'b1; av_filter = 1'b1; co_filter = 1'b0;
      step("rst_config", E_CFG);
      step("rst_fetch", E_BUSY);
      step("rst_mac", E_ISSUE);
      rst = 1'b1;
      step("rst_mac_hold", E_ISSUE);
      rst = 1'b0;
      step("rst_after", E_IDLE);
      check("rst_no_done", 32'(done_cnt - d0), 32'd0);
      run_job(2, 1, 2, 0, 1'b0);

      run_job(2, 2, 2, 2, 1'b1);
      for (int i = 0; i < 6; i++)
         run_job($urandom_range(0, 4), $urandom_range(1, 3), $urandom_range(1, 5), 2,
                 1'($urandom_range(0, 1)));
      run_job(255, 1, 1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pe_sequencer
